spi_fetch_arbiter: RTL

SPI_FETCH_ARBITER -- requirements
Module: spi_fetch_arbiter

---
 rtl/spi_fetch_arbiter_if.sv | 42 ++++
 rtl/spi_fetch_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_fetch_arbiter_if
// Requester-side bus of the SPI EEPROM read arbiter. Two requesters share it:
// instruction fetch and config/constant load.
//
// Handshake: a requester raises req_* with its byte address and holds both
// until its one-cycle rvalid_* pulse. gnt_* is a one-cycle pulse that marks
// the moment the arbiter latched that requester's address; dropping req_*
// after the grant does not cancel the read. rdata is meaningful in the
// rvalid_* cycle and holds until the next rvalid. A req_* still high in the
// cycle after its rvalid_* counts as a new request.
//
// Signals:
//   req_fetch/fetch_addr[9:0], req_cfg/cfg_addr[9:0]  requester -> arbiter
//   gnt_fetch, gnt_cfg                                arbiter -> requester
//   rdata[7:0], rvalid_fetch, rvalid_cfg              arbiter -> requester
//   busy                                              arbiter not in IDLE
//   dbg_state[2:0]                                    current FSM state code
// ---------------------------------------------------------------------------
interface spi_fetch_arbiter_if;
  logic       req_fetch;
  logic [9:0] fetch_addr;
  logic       req_cfg;
  logic [9:0] cfg_addr;
  logic       gnt_fetch;
  logic       gnt_cfg;
  logic [7:0] rdata;
  logic       rvalid_fetch;
  logic       rvalid_cfg;
  logic       busy;
  logic [2:0] dbg_state;

  modport master (
    output req_fetch, fetch_addr, req_cfg, cfg_addr,
    input  gnt_fetch, gnt_cfg, rdata, rvalid_fetch, rvalid_cfg, busy, dbg_state
  );

  modport slave (
    input  req_fetch, fetch_addr, req_cfg, cfg_addr,
    output gnt_fetch, gnt_cfg, rdata, rvalid_fetch, rvalid_cfg, busy, dbg_state
  );
endinterface

// File: rtl/spi_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// spi_fetch_arbiter
// Arbitrates instruction-fetch and config reads onto one SPI EEPROM (mode 0,
// sck = clk/2) using the READ command 8'h03 followed by a 16-bit address
// {6'b0, addr[9:8]}, {addr[7:0]} and one data byte.
//
// Ports:
//   clk, rst       sole clock; synchronous active-high reset
//   bus (slave)    requester handshake, see spi_fetch_arbiter_if
//   spi_cs_n       chip select, active low
//   spi_sck        SPI clock, idles low
//   spi_copi       controller -> EEPROM data
//   spi_cipo       EEPROM -> controller data
//
// Timing (grant pulse in cycle T): cs_n low from T+1, command/address/data
// bits occupy T+1..T+64, rvalid at T+65 together with the one-cycle DONE
// (cs_n high), IDLE at T+66, earliest next grant T+67.
//
// Optional feature, macro SPI_BURST_CONTINUE_EN: after a read the chip stays
// selected in HOLD; a granted request for previous address + 1 skips
// command and address and goes straight to DATA (rvalid at grant+17). Any
// other request, or 16 idle cycles in HOLD, closes the burst through DONE.
// ---------------------------------------------------------------------------
module spi_fetch_arbiter (
  input  logic                       clk,
  input  logic                       rst,
  spi_fetch_arbiter_if.slave         bus,
  output logic                       spi_cs_n,
  output logic                       spi_sck,
  output logic                       spi_copi,
  input  logic                       spi_cipo
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDRH = 3'd2,
    S_ADDRL = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
`ifdef SPI_BURST_CONTINUE_EN
    , S_HOLD = 3'd6
`endif
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  state_t     state_q, state_d;
  logic       ph_q, ph_d;             // 0: sck low / copi set, 1: sck high
  logic [2:0] bit_q, bit_d;
  logic [6:0] sh_q, sh_d;             // bits still to send after current one
  logic [6:0] rx_q, rx_d;             // data bits received so far
  logic [9:0] addr_q, addr_d;
  logic       own_cfg_q, own_cfg_d;   // owner of the transaction in flight
  logic       last_cfg_q, last_cfg_d; // last grant went to cfg
  logic       gnt_fetch_q, gnt_fetch_d;
  logic       gnt_cfg_q, gnt_cfg_d;
  logic       rvalid_fetch_q, rvalid_fetch_d;
  logic       rvalid_cfg_q, rvalid_cfg_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_n_q, cs_n_d;
  logic       sck_q, sck_d;
  logic       copi_q, copi_d;
`ifdef SPI_BURST_CONTINUE_EN
  logic [3:0] hold_cnt_q, hold_cnt_d;
`endif

  // A requester is blind in its own rvalid cycle: its req is still the old
  // one there; from the next cycle on a held req is a new request.
  logic       eff_fetch, eff_cfg, any_req, pick_cfg, gnt_pend;
  logic [9:0] win_addr;

  assign eff_fetch = bus.req_fetch & ~rvalid_fetch_q;
  assign eff_cfg   = bus.req_cfg & ~rvalid_cfg_q;
  assign any_req   = eff_fetch | eff_cfg;
  // On a tie the side not granted last wins.
  assign pick_cfg  = eff_cfg & (~eff_fetch | ~last_cfg_q);
  assign win_addr  = pick_cfg ? bus.cfg_addr : bus.fetch_addr;
  assign gnt_pend  = gnt_fetch_q | gnt_cfg_q;

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    bit_d          = bit_q;
    sh_d           = sh_q;
    rx_d           = rx_q;
    addr_d         = addr_q;
    own_cfg_d      = own_cfg_q;
    last_cfg_d     = last_cfg_q;
    gnt_fetch_d    = 1'b0;
    gnt_cfg_d      = 1'b0;
    rvalid_fetch_d = 1'b0;
    rvalid_cfg_d   = 1'b0;
    rdata_d        = rdata_q;
    cs_n_d         = cs_n_q;
    sck_d          = sck_q;
    copi_d         = copi_q;
`ifdef SPI_BURST_CONTINUE_EN
    hold_cnt_d     = hold_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_pend) begin
          // Grant cycle done: select the chip and present the first bit.
          state_d = S_CMD;
          ph_d    = 1'b0;
          bit_d   = 3'd0;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          copi_d  = CMD_READ[7];
          sh_d    = CMD_READ[6:0];
        end else if (any_req) begin
          gnt_fetch_d = ~pick_cfg;
          gnt_cfg_d   = pick_cfg;
          own_cfg_d   = pick_cfg;
          last_cfg_d  = pick_cfg;
          addr_d      = win_addr;
        end
      end
      S_CMD, S_ADDRH, S_ADDRL, S_DATA: begin
        if (!ph_q) begin
          ph_d  = 1'b1;
          sck_d = 1'b1;
        end else begin
          ph_d  = 1'b0;
          sck_d = 1'b0;
          if (state_q == S_DATA) rx_d = {rx_q[5:0], spi_cipo};
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            copi_d = sh_q[6];
            sh_d   = {sh_q[5:0], 1'b0};
          end else begin
            bit_d = 3'd0;
            case (state_q)
              S_CMD: begin
                state_d = S_ADDRH;
                copi_d  = 1'b0;
                sh_d    = {5'b0, addr_q[9:8]};
              end
              S_ADDRH: begin
                state_d = S_ADDRL;
                copi_d  = addr_q[7];
                sh_d    = addr_q[6:0];
              end
              S_ADDRL: begin
                state_d = S_DATA;
                copi_d  = 1'b0;
                sh_d    = 7'd0;
              end
              default: begin
                rdata_d        = {rx_q, spi_cipo};
                rvalid_fetch_d = ~own_cfg_q;
                rvalid_cfg_d   = own_cfg_q;
                copi_d         = 1'b0;
`ifdef SPI_BURST_CONTINUE_EN
                state_d    = S_HOLD;
                hold_cnt_d = 4'd0;
`else
                state_d = S_DONE;
                cs_n_d  = 1'b1;
`endif
              end
            endcase
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef SPI_BURST_CONTINUE_EN
      S_HOLD: begin
        if (gnt_pend) begin
          // The EEPROM auto-increments, so only the data byte is needed.
          state_d = S_DATA;
          ph_d    = 1'b0;
          bit_d   = 3'd0;
          copi_d  = 1'b0;
          sh_d    = 7'd0;
        end else if (any_req) begin
          if ((addr_q != 10'h3FF) && (win_addr == addr_q + 10'd1)) begin
            gnt_fetch_d = ~pick_cfg;
            gnt_cfg_d   = pick_cfg;
            own_cfg_d   = pick_cfg;
            last_cfg_d  = pick_cfg;
            addr_d      = win_addr;
          end else begin
            // Not a continuation: close the burst; IDLE re-arbitrates.
            state_d = S_DONE;
            cs_n_d  = 1'b1;
          end
        end else if (hold_cnt_q == 4'd15) begin
          state_d = S_DONE;
          cs_n_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        copi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ph_q           <= 1'b0;
      bit_q          <= 3'd0;
      sh_q           <= 7'd0;
      rx_q           <= 7'd0;
      addr_q         <= 10'd0;
      own_cfg_q      <= 1'b0;
      last_cfg_q     <= 1'b1;
      gnt_fetch_q    <= 1'b0;
      gnt_cfg_q      <= 1'b0;
      rvalid_fetch_q <= 1'b0;
      rvalid_cfg_q   <= 1'b0;
      rdata_q        <= 8'h00;
      cs_n_q         <= 1'b1;
      sck_q          <= 1'b0;
      copi_q         <= 1'b0;
`ifdef SPI_BURST_CONTINUE_EN
      hold_cnt_q     <= 4'd0;
`endif
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      bit_q          <= bit_d;
      sh_q           <= sh_d;
      rx_q           <= rx_d;
      addr_q         <= addr_d;
      own_cfg_q      <= own_cfg_d;
      last_cfg_q     <= last_cfg_d;
      gnt_fetch_q    <= gnt_fetch_d;
      gnt_cfg_q      <= gnt_cfg_d;
      rvalid_fetch_q <= rvalid_fetch_d;
      rvalid_cfg_q   <= rvalid_cfg_d;
      rdata_q        <= rdata_d;
      cs_n_q         <= cs_n_d;
      sck_q          <= sck_d;
      copi_q         <= copi_d;
`ifdef SPI_BURST_CONTINUE_EN
      hold_cnt_q     <= hold_cnt_d;
`endif
    end
  end

  assign bus.gnt_fetch    = gnt_fetch_q;
  assign bus.gnt_cfg      = gnt_cfg_q;
  assign bus.rvalid_fetch = rvalid_fetch_q;
  assign bus.rvalid_cfg   = rvalid_cfg_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.dbg_state    = state_q;
  assign spi_cs_n         = cs_n_q;
  assign spi_sck          = sck_q;
  assign spi_copi         = copi_q;

endmodule
